load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit_if.sv | 38 +++
 rtl/load_align_unit.sv | 125 ++++++++++++
 tb/tb_load_align_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: load access type encoding and request/line/response bundle for load_align_unit
typedef enum logic [3:0] {
  LST_BYTE    = 4'd0,
  LST_UBYTE   = 4'd1,
  LST_HALF    = 4'd2,
  LST_UHALF   = 4'd3,
  LST_WORD    = 4'd4,
  LST_UWORD   = 4'd5,
  LST_FPWORD  = 4'd6,
  LST_DOUBLE  = 4'd7,
  LST_INVALID = 4'hF
} LoadStoreType;

interface load_align_if #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = $clog2(LINE_SIZE)
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  LoadStoreType           req_type;
  logic                   line_valid;
  logic                   line_ready;
  logic [LINE_SIZE*8-1:0] line_data;
  logic                   next_line_req;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [63:0]            resp_data;
  logic                   resp_misaligned;
  modport master (
    output req_valid, req_addr, req_type, line_valid, line_data, resp_ready,
    input  req_ready, line_ready, next_line_req, resp_valid, resp_data, resp_misaligned
  );
  modport slave (
    input  req_valid, req_addr, req_type, line_valid, line_data, resp_ready,
    output req_ready, line_ready, next_line_req, resp_valid, resp_data, resp_misaligned
  );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: extracts, aligns and extends a load from D-cache line beats; LOAD_ALIGN_LINE_CROSS_EN services line-crossing loads with a second beat
module load_align_unit #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = $clog2(LINE_SIZE)
) (
  input logic clk,
  input logic rst_n,
  load_align_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_SECOND, RESP} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] off_q;
  LoadStoreType          type_q;
  logic [63:0]           data_q, data_d, asm_w;
  logic                  mis_q, mis_d, pulse_q, pulse_d, accept, cross_in;
`ifdef LOAD_ALIGN_LINE_CROSS_EN
  logic                  cross_q;
  logic [63:0]           buf_q;
`endif

  function automatic logic [3:0] size_of(input LoadStoreType t);
    return (t == LST_HALF || t == LST_UHALF) ? 4'd2 :
           (t == LST_WORD || t == LST_UWORD || t == LST_FPWORD) ? 4'd4 :
           (t == LST_DOUBLE) ? 4'd8 : 4'd1;
  endfunction

  function automatic logic [63:0] extend(input LoadStoreType t, input logic [63:0] a);
    return (t == LST_BYTE)   ? {{56{a[7]}}, a[7:0]} :
           (t == LST_UBYTE)  ? {56'd0, a[7:0]} :
           (t == LST_HALF)   ? {{48{a[15]}}, a[15:0]} :
           (t == LST_UHALF)  ? {48'd0, a[15:0]} :
           (t == LST_WORD)   ? {{32{a[31]}}, a[31:0]} :
           (t == LST_UWORD)  ? {32'd0, a[31:0]} :
           (t == LST_FPWORD) ? {32'hFFFF_FFFF, a[31:0]} :
           (t == LST_DOUBLE) ? a : 64'd0;
  endfunction

  assign accept   = bus.req_valid && state_q == IDLE;
  assign cross_in = ({1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(size_of(bus.req_type))) > (ADDR_WIDTH+1)'(LINE_SIZE);

  // result byte b comes from line offset off+b modulo the line; wrapped bytes belong to the second beat
  for (genvar b = 0; b < 8; b++) begin : g_byte
    logic [ADDR_WIDTH-1:0] lo;
    assign lo = off_q + ADDR_WIDTH'(b);
`ifdef LOAD_ALIGN_LINE_CROSS_EN
    logic wrap;
    assign wrap = ({1'b0, off_q} + (ADDR_WIDTH+1)'(b)) >= (ADDR_WIDTH+1)'(LINE_SIZE);
    assign asm_w[8*b +: 8] = (state_q == WAIT_SECOND && !wrap) ? buf_q[8*b +: 8] : bus.line_data[{lo, 3'b000} +: 8];
`else
    assign asm_w[8*b +: 8] = bus.line_data[{lo, 3'b000} +: 8];
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mis_d   = mis_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
`ifdef LOAD_ALIGN_LINE_CROSS_EN
        state_d = WAIT_FIRST;
`else
        state_d = cross_in ? RESP : WAIT_FIRST;
        data_d  = 64'd0;
        mis_d   = cross_in;
`endif
      end
      WAIT_FIRST: if (bus.line_valid) begin
`ifdef LOAD_ALIGN_LINE_CROSS_EN
        state_d = cross_q ? WAIT_SECOND : RESP;
        pulse_d = cross_q;
`else
        state_d = RESP;
`endif
        data_d  = extend(type_q, asm_w);
        mis_d   = 1'b0;
      end
      WAIT_SECOND: if (bus.line_valid) begin
        state_d = RESP;
        data_d  = extend(type_q, asm_w);
        mis_d   = 1'b0;
      end
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      type_q  <= LST_BYTE;
      data_q  <= '0;
      mis_q   <= 1'b0;
      pulse_q <= 1'b0;
`ifdef LOAD_ALIGN_LINE_CROSS_EN
      cross_q <= 1'b0;
      buf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      pulse_q <= pulse_d;
      if (accept) begin
        off_q  <= bus.req_addr;
        type_q <= bus.req_type;
`ifdef LOAD_ALIGN_LINE_CROSS_EN
        cross_q <= cross_in;
`endif
      end
`ifdef LOAD_ALIGN_LINE_CROSS_EN
      if (state_q == WAIT_FIRST && bus.line_valid) buf_q <= asm_w;
`endif
    end
  end

  assign bus.req_ready       = state_q == IDLE;
  assign bus.line_ready      = state_q == WAIT_FIRST || state_q == WAIT_SECOND;
  assign bus.resp_valid      = state_q == RESP;
  assign bus.resp_data       = data_q;
  assign bus.resp_misaligned = mis_q;
  assign bus.next_line_req   = pulse_q;
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed and randomized checks of load_align_unit against a byte-level reference model
module tb_load_align_unit;
  localparam int LS = 16;
`ifdef LOAD_ALIGN_LINE_CROSS_EN
  localparam bit CROSS = 1'b1;
`else
  localparam bit CROSS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [LS*8-1:0] l1_fix, l2_fix;
  LoadStoreType types [9];

  load_align_if #(.LINE_SIZE(LS)) bus();
  load_align_unit #(.LINE_SIZE(LS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic int tsize(input LoadStoreType t);
    case (t)
      LST_HALF, LST_UHALF: return 2;
      LST_WORD, LST_UWORD, LST_FPWORD: return 4;
      LST_DOUBLE: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic void model(input logic [LS*8-1:0] l1, input logic [LS*8-1:0] l2, input logic [3:0] a,
                                input LoadStoreType t, output logic [63:0] d, output logic m);
    int sz;
    logic [63:0] v;
    sz = tsize(t);
    v = '0;
    m = !CROSS && (int'(a) + sz > LS);
    for (int j = 0; j < sz; j++) begin
      int k;
      k = int'(a) + j;
      v[8*j +: 8] = (k < LS) ? l1[8*k +: 8] : l2[8*(k-LS) +: 8];
    end
    if ((t == LST_BYTE || t == LST_HALF || t == LST_WORD) && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    if (t == LST_FPWORD) v[63:32] = '1;
    if (t == LST_INVALID || m) v = '0;
    d = v;
  endfunction

  task automatic scramble();
    bus.line_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_load(input logic [3:0] a, input LoadStoreType t, input logic [LS*8-1:0] l1, input logic [LS*8-1:0] l2,
                          input logic [63:0] ed, input logic em, input int hold, input string name);
    int n;
    bit two;
    two = !em && (int'(a) + tsize(t) > LS);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready wait got %b want 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_type  = t;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 4'($urandom);
    bus.req_type  = types[$urandom_range(0, 8)];
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s req_ready busy got %b want 0", name, bus.req_ready);
    end
    if (!em) begin
      checks++;
      if (bus.line_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.next_line_req !== 1'b0) begin
        errors++;
        $display("FAIL %s first_wait got lr=%b rv=%b nlr=%b want 1 0 0", name, bus.line_ready, bus.resp_valid, bus.next_line_req);
      end
      bus.line_valid = 1'b1;
      bus.line_data  = l1;
      @(negedge clk);
      bus.line_valid = 1'b0;
      scramble();
      if (two) begin
        checks++;
        if (bus.next_line_req !== 1'b1 || bus.line_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s second_wait got nlr=%b lr=%b rv=%b want 1 1 0", name, bus.next_line_req, bus.line_ready, bus.resp_valid);
        end
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          checks++;
          if (bus.next_line_req !== 1'b0 || bus.line_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s nlr_pulse got nlr=%b lr=%b want 0 1", name, bus.next_line_req, bus.line_ready);
          end
        end
        bus.line_valid = 1'b1;
        bus.line_data  = l2;
        @(negedge clk);
        bus.line_valid = 1'b0;
        scramble();
      end
    end else begin
      checks++;
      if (bus.line_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s mis_line_ready got %b want 0", name, bus.line_ready);
      end
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== ed || bus.resp_misaligned !== em) begin
      errors++;
      $display("FAIL %s resp got v=%b d=%h m=%b want v=1 d=%h m=%b", name, bus.resp_valid, bus.resp_data, bus.resp_misaligned, ed, em);
    end
    repeat (hold) begin
      bus.line_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== ed || bus.resp_misaligned !== em ||
          bus.req_ready !== 1'b0 || bus.line_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold got v=%b d=%h m=%b rr=%b lr=%b want v=1 d=%h m=%b rr=0 lr=0", name, bus.resp_valid,
                 bus.resp_data, bus.resp_misaligned, bus.req_ready, bus.line_ready, ed, em);
      end
    end
    bus.line_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release got rv=%b rr=%b want 0 1", name, bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.line_ready !== 1'b0 || bus.next_line_req !== 1'b0 ||
        bus.resp_valid !== 1'b0 || bus.resp_data !== 64'd0 || bus.resp_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs got rr=%b lr=%b nlr=%b rv=%b d=%h m=%b want 1 0 0 0 0 0", name, bus.req_ready,
               bus.line_ready, bus.next_line_req, bus.resp_valid, bus.resp_data, bus.resp_misaligned);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_directed();
    run_load(4'd3, LST_BYTE, l1_fix, l2_fix, 64'hFFFF_FFFF_FFFF_FF83, 1'b0, 0, "byte3");
    run_load(4'd4, LST_UHALF, l1_fix, l2_fix, 64'h0000_0000_0000_8584, 1'b0, 1, "uhalf4");
    run_load(4'd0, LST_FPWORD, l1_fix, l2_fix, 64'hFFFF_FFFF_8382_8180, 1'b0, 0, "fp0");
    run_load(4'd0, LST_WORD, l1_fix, l2_fix, 64'hFFFF_FFFF_8382_8180, 1'b0, 0, "word0");
    run_load(4'd12, LST_UWORD, l1_fix, l2_fix, 64'h0000_0000_8F8E_8D8C, 1'b0, 0, "uword12");
    run_load(4'd14, LST_WORD, l1_fix, l2_fix, CROSS ? 64'h0000_0000_1110_8F8E : 64'd0, !CROSS, 1, "word14");
    run_load(4'd15, LST_INVALID, l1_fix, l2_fix, 64'd0, 1'b0, 0, "invalid15");
  endtask

  task automatic test_backpressure();
    run_load(4'd8, LST_DOUBLE, l1_fix, l2_fix, 64'h8F8E_8D8C_8B8A_8988, 1'b0, 3, "dbl8_hold3");
  endtask

  task automatic test_ignored_line();
    repeat (3) begin
      bus.line_valid = 1'b1;
      scramble();
      @(negedge clk);
      checks++;
      if (bus.line_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_line got lr=%b rv=%b rr=%b want 0 0 1", bus.line_ready, bus.resp_valid, bus.req_ready);
      end
    end
    bus.line_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1;
    bus.req_addr  = 4'd14;
    bus.req_type  = LST_WORD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.line_ready) begin
      bus.line_valid = 1'b1;
      bus.line_data  = l1_fix;
      @(negedge clk);
      bus.line_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_load(4'd2, LST_HALF, l1_fix, l2_fix, 64'hFFFF_FFFF_FFFF_8382, 1'b0, 1, "after_reset");
  endtask

  task automatic test_random();
    logic [LS*8-1:0] l1, l2;
    logic [63:0] ed;
    logic em;
    logic [3:0] a;
    LoadStoreType t;
    for (int i = 0; i < 150; i++) begin
      l1 = {$urandom, $urandom, $urandom, $urandom};
      l2 = {$urandom, $urandom, $urandom, $urandom};
      a  = 4'($urandom);
      t  = types[$urandom_range(0, 8)];
      model(l1, l2, a, t, ed, em);
      run_load(a, t, l1, l2, ed, em, $urandom_range(0, 3), $sformatf("rand%0d_%0d_%0d", i, a, t));
    end
  endtask

  initial begin
    types = '{LST_BYTE, LST_UBYTE, LST_HALF, LST_UHALF, LST_WORD, LST_UWORD, LST_FPWORD, LST_DOUBLE, LST_INVALID};
    for (int i = 0; i < LS; i++) begin
      l1_fix[8*i +: 8] = 8'(8'h80 + i);
      l2_fix[8*i +: 8] = 8'(8'h10 + i);
    end
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_type   = LST_BYTE;
    bus.line_valid = 1'b0;
    bus.line_data  = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_ignored_line();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
